// File: rtl/time_preset_entry.sv
// MM:SS BCD preset editor: select a digit with sel, step it with inc/dec (auto-repeat), commit.
// Optional macro TIME_PRESET_ABORT_EN adds abort_p_i, which restores the pre-edit value.
module time_preset_entry #(
  parameter int unsigned BLINK_DIV    = 12500000,
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 6250000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel_p_i,
  input  logic        inc_lvl_i,
  input  logic        dec_lvl_i,
`ifdef TIME_PRESET_ABORT_EN
  input  logic        abort_p_i,
`endif
  output logic [15:0] preset_bcd_o,
  output logic        load_o,
  output logic        editing_o,
  output logic [3:0]  blank_o
);

  localparam int unsigned HoldW  = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  localparam int unsigned BlinkW = $clog2(BLINK_DIV + 1);

  typedef enum logic [2:0] {StIdle, StEM1, StEM0, StES1, StES0} state_e;

  state_e             state_q, state_d;
  logic [15:0]        preset_q, preset_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [BlinkW-1:0]  blink_q, blink_d;
  logic               phase_q, phase_d;
  logic               load_q, load_d;
  logic               editing_q;
  logic [3:0]         blank_q, blank_d;
  logic               inc_q, dec_q;
  logic               inc_only, dec_only, rise, step, abort_req;
  logic [HoldW-1:0]   hold_inc;

  function automatic logic [3:0] bump(input logic [3:0] d, input logic up, input logic [3:0] max);
    if (up) return (d == max) ? 4'd0 : d + 4'd1;
    else    return (d == 4'd0) ? max : d - 4'd1;
  endfunction

`ifdef TIME_PRESET_ABORT_EN
  logic [15:0] shadow_q, shadow_d;
  assign abort_req = abort_p_i && (state_q != StIdle);
`else
  assign abort_req = 1'b0;
`endif

  assign inc_only = inc_lvl_i & ~dec_lvl_i;
  assign dec_only = dec_lvl_i & ~inc_lvl_i;
  assign rise     = (inc_only & ~inc_q) | (dec_only & ~dec_q);
  assign hold_inc = hold_q + HoldW'(1);

  always_comb begin
    state_d  = state_q;
    preset_d = preset_q;
    hold_d   = hold_q;
    blink_d  = blink_q;
    phase_d  = phase_q;
    load_d   = 1'b0;
    blank_d  = 4'b0000;
    step     = 1'b0;
`ifdef TIME_PRESET_ABORT_EN
    shadow_d = shadow_q;
`endif

    // Hold counter: immediate step on press, then delay, then fixed-rate repeat.
    if (!inc_only && !dec_only) begin
      hold_d = '0;
    end else if (rise) begin
      step   = 1'b1;
      hold_d = '0;
    end else if (hold_inc == HoldW'(REPEAT_DELAY)) begin
      step   = 1'b1;
      hold_d = hold_inc;
    end else if (hold_inc == HoldW'(REPEAT_DELAY + REPEAT_RATE)) begin
      step   = 1'b1;
      hold_d = HoldW'(REPEAT_DELAY);
    end else begin
      hold_d = hold_inc;
    end

    if (state_q == StIdle) begin
      step   = 1'b0;
      hold_d = '0;
      if (sel_p_i) begin
        state_d  = StEM1;
`ifdef TIME_PRESET_ABORT_EN
        shadow_d = preset_q;
`endif
      end
    end else if (abort_req) begin
`ifdef TIME_PRESET_ABORT_EN
      preset_d = shadow_q;
`endif
      state_d = StIdle;
    end else if (sel_p_i) begin
      unique case (state_q)
        StEM1:   state_d = StEM0;
        StEM0:   state_d = StES1;
        StES1:   state_d = StES0;
        default: begin
          state_d = StIdle;
          load_d  = 1'b1;
        end
      endcase
    end else if (step) begin
      unique case (state_q)
        StEM1:   preset_d[15:12] = bump(preset_q[15:12], inc_only, 4'd5);
        StEM0:   preset_d[11:8]  = bump(preset_q[11:8], inc_only, 4'd9);
        StES1:   preset_d[7:4]   = bump(preset_q[7:4], inc_only, 4'd5);
        default: preset_d[3:0]   = bump(preset_q[3:0], inc_only, 4'd9);
      endcase
    end

    // Any change restarts the blink so the digit is visible right away.
    if (state_d != state_q) begin
      hold_d  = '0;
      blink_d = '0;
      phase_d = 1'b0;
    end else if (state_q == StIdle || step) begin
      blink_d = '0;
      phase_d = 1'b0;
    end else if (blink_q == BlinkW'(BLINK_DIV - 1)) begin
      blink_d = '0;
      phase_d = ~phase_q;
    end else begin
      blink_d = blink_q + BlinkW'(1);
    end

    if (phase_q) begin
      unique case (state_q)
        StEM1:   blank_d = 4'b1000;
        StEM0:   blank_d = 4'b0100;
        StES1:   blank_d = 4'b0010;
        StES0:   blank_d = 4'b0001;
        default: blank_d = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      preset_q  <= 16'h0000;
      hold_q    <= '0;
      blink_q   <= '0;
      phase_q   <= 1'b0;
      load_q    <= 1'b0;
      editing_q <= 1'b0;
      blank_q   <= 4'b0000;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
`ifdef TIME_PRESET_ABORT_EN
      shadow_q  <= 16'h0000;
`endif
    end else begin
      state_q   <= state_d;
      preset_q  <= preset_d;
      hold_q    <= hold_d;
      blink_q   <= blink_d;
      phase_q   <= phase_d;
      load_q    <= load_d;
      editing_q <= (state_q != StIdle);
      blank_q   <= blank_d;
      inc_q     <= inc_lvl_i;
      dec_q     <= dec_lvl_i;
`ifdef TIME_PRESET_ABORT_EN
      shadow_q  <= shadow_d;
`endif
    end
  end

  assign preset_bcd_o = preset_q;
  assign load_o       = load_q;
  assign editing_o    = editing_q;
  assign blank_o      = blank_q;

endmodule

// File: tb/tb_time_preset_entry.sv
// Directed bench for time_preset_entry; committed words are checked through a load scoreboard.
module tb_time_preset_entry;
  localparam int unsigned BD = 4;
  localparam int unsigned RD = 8;
  localparam int unsigned RR = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel_p = 1'b0;
  logic        inc = 1'b0;
  logic        dec = 1'b0;
`ifdef TIME_PRESET_ABORT_EN
  logic        abort_p = 1'b0;
`endif
  logic [15:0] preset;
  logic        load;
  logic        editing;
  logic [3:0]  blank;

  int          checks = 0;
  int          errors = 0;
  int          loads_seen = 0;
  int          pushes = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mid_val;
  int          exp_m0;

  time_preset_entry #(
    .BLINK_DIV   (BD),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sel_p_i     (sel_p),
    .inc_lvl_i   (inc),
    .dec_lvl_i   (dec),
`ifdef TIME_PRESET_ABORT_EN
    .abort_p_i   (abort_p),
`endif
    .preset_bcd_o(preset),
    .load_o      (load),
    .editing_o   (editing),
    .blank_o     (blank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_sel();
    sel_p = 1'b1;
    cyc(1);
    sel_p = 1'b0;
  endtask

  task automatic tap(input logic up, input int n);
    for (int i = 0; i < n; i++) begin
      if (up) inc = 1'b1;
      else    dec = 1'b1;
      cyc(1);
      inc = 1'b0;
      dec = 1'b0;
      cyc(1);
    end
  endtask

  task automatic commit(input logic [15:0] word);
    exp_q.push_back(word);
    pushes++;
    pulse_sel();
  endtask

  // Scoreboard: every load strobe must match the next queued word.
  always @(negedge clk) begin
    if (rst_n && load === 1'b1) begin
      loads_seen++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_load: observed load with %h expected no load", preset);
      end
      if (exp_q.size() > 0) chk("load_word", preset, exp_q.pop_front());
    end
  end

  initial begin
    cyc(2);
    chk("rst_preset", preset, 16'h0000);
    chk("rst_load", {15'b0, load}, 16'h0000);
    chk("rst_editing", {15'b0, editing}, 16'h0000);
    chk("rst_blank", {12'b0, blank}, 16'h0000);
    rst_n = 1'b1;
    cyc(1);

    pulse_sel();
    cyc(1);
    chk("editing_on", {15'b0, editing}, 16'h0001);
    pulse_sel();
    pulse_sel();
    pulse_sel();
    commit(16'h0000);
    chk("load_pulse", {15'b0, load}, 16'h0001);
    cyc(1);
    chk("load_one_cycle", {15'b0, load}, 16'h0000);
    chk("editing_off", {15'b0, editing}, 16'h0000);

    pulse_sel();
    tap(1'b1, 2);
    chk("m1_steps", preset, 16'h2000);
    pulse_sel();
    tap(1'b1, 3);
    pulse_sel();
    tap(1'b0, 1);
    chk("s1_dec_wrap", preset, 16'h2350);
    pulse_sel();
    tap(1'b1, 9);
    commit(16'h2359);

    pulse_sel();
    tap(1'b0, 3);
    chk("m1_wrap_down", preset, 16'h5359);
    pulse_sel();
    pulse_sel();
    pulse_sel();
    tap(1'b1, 1);
    chk("s0_wrap_no_carry", preset, 16'h5350);
    commit(16'h5350);

    pulse_sel();
    pulse_sel();
    tap(1'b0, 3);
    chk("m0_zero", preset, 16'h5050);
    exp_m0 = 0;
    inc = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      if (k == 0 || (k >= int'(RD) && ((k - int'(RD)) % int'(RR)) == 0)) exp_m0++;
      chk("autorep_m0", {12'b0, preset[11:8]}, 16'(exp_m0));
    end
    inc = 1'b0;
    cyc(1);
    chk("autorep_final", preset, 16'h5750);

    inc = 1'b1;
    dec = 1'b1;
    cyc(20);
    chk("both_held", preset, 16'h5750);
    inc = 1'b0;
    dec = 1'b0;
    cyc(1);

    sel_p = 1'b1;
    inc = 1'b1;
    cyc(1);
    sel_p = 1'b0;
    chk("sel_wins", preset, 16'h5750);
    cyc(7);
    chk("no_early_repeat", preset, 16'h5750);
    cyc(1);
    chk("repeat_after_delay", preset, 16'h5700);
    inc = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      cyc(1);
      chk("blink_s1", {12'b0, blank}, (((k - 1) / int'(BD)) % 2) != 0 ? 16'h0002 : 16'h0000);
    end
    pulse_sel();
    commit(16'h5700);

    tap(1'b1, 2);
    tap(1'b0, 1);
    chk("idle_ignore", preset, 16'h5700);
    chk("idle_editing", {15'b0, editing}, 16'h0000);

`ifdef TIME_PRESET_ABORT_EN
    pulse_sel();
    tap(1'b1, 2);
    pulse_sel();
    tap(1'b1, 5);
    pulse_sel();
    tap(1'b1, 3);
    pulse_sel();
    tap(1'b1, 4);
    commit(16'h1234);
    pulse_sel();
    tap(1'b1, 4);
    chk("abort_pre", preset, 16'h5234);
    abort_p = 1'b1;
    cyc(1);
    abort_p = 1'b0;
    chk("abort_restore", preset, 16'h1234);
    cyc(1);
    chk("abort_editing", {15'b0, editing}, 16'h0000);
    mid_val = 16'h3234;
`else
    mid_val = 16'h1700;
`endif

    pulse_sel();
    tap(1'b1, 2);
    chk("mid_edit", preset, mid_val);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_preset", preset, 16'h0000);
    chk("async_rst_editing", {15'b0, editing}, 16'h0000);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    chk("post_rst_preset", preset, 16'h0000);
    chk("queue_empty", 16'(exp_q.size()), 16'h0000);
    chk("load_count", 16'(loads_seen), 16'(pushes));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
